csa_accumulator: RTL
====================

CSA_ACCUMULATOR -- requirements
Module: csa_accumulator

Interface
REQ-001 SHALL have parameter DW, default 64: input operand width.
REQ-002 SHALL have parameter GW, default 4: guard bits above DW.
REQ-003 SHALL derive AW = DW+GW as the accumulator/result width.
REQ-004 SHALL use one clock and an asynchronous, active-high reset.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 in_valid  input  1  operand beat valid.
REQ-008 in_ready  output  1  block can accept a beat.
REQ-009 in_data  input  DW  unsigned operand.
REQ-010 in_last  input  1  final beat of the current group.
REQ-011 out_valid  output  1  resolved sum available.
REQ-012 out_ready  input  1  consumer accepts the sum.
REQ-013 out_data  output  AW  resolved group sum.

Function
REQ-014 SHALL have states ACC, RES and OUT (plus RES_HI when the split-resolve macro is defined).
REQ-015 A beat SHALL be accepted on a rising edge where in_valid=1 and in_ready=1.
REQ-016 in_ready SHALL be 1 in ACC only.
REQ-017 out_valid SHALL be 1 in OUT only.
REQ-018 SHALL hold the running sum in carry-save form as registers S[AW-1:0] and C[AW-1:0]; the represented value is S + (C<<1) mod 2^AW.
REQ-019 On each accepted beat, with x = zero-extended in_data and K = C<<1 truncated to AW bits: S <= x^S^K and C <= maj(x,S,K), bitwise (one full-adder row, no carry propagation).
REQ-020 ACC SHALL accept one beat per cycle with no bubbles.
REQ-021 An accepted beat with in_last=1 SHALL be included in S/C, and the state SHALL go ACC->RES.
REQ-022 In RES (non-split), the next edge SHALL do all of the following:
- out_data <= S + (C<<1) mod 2^AW;
- clear S and C to 0;
- go to OUT.
REQ-023 Without split resolve, out_valid SHALL rise on the 2nd edge after the edge that accepts the in_last beat.
REQ-024 Overflow SHALL wrap modulo 2^AW with no flag; GW guard bits make groups of up to 2^GW beats exact.
REQ-025 A single-beat group (in_last on its first beat) SHALL produce out_data = zero-extended in_data.
REQ-026 In OUT, out_data SHALL be held stable until out_ready=1.
REQ-027 On an edge where out_valid=1 and out_ready=1, the state SHALL go OUT->ACC, with in_ready=1 in the following cycle.
REQ-028 in_valid in non-ACC states SHALL be ignored (no acceptance, no S/C change).
REQ-029 out_ready outside OUT SHALL be ignored.

Reset
REQ-030 reset=1 SHALL, immediately and regardless of clk:
- force state ACC;
- clear S, C and out_data to 0;
- drive out_valid=0 and in_ready=1.
REQ-031 Reset mid-group or mid-resolve SHALL discard the partial sum; the first post-reset beat SHALL start a new group.

Configuration
REQ-032 Macro CSA_SPLIT_CPA_EN SHALL select split resolve.
REQ-033 With CSA_SPLIT_CPA_EN defined, resolve SHALL take two edges:
- RES: lower ceil(AW/2) bits of out_data are computed and the carry-out is registered;
- RES_HI: upper bits are computed from that registered carry, S/C are cleared, and the state goes to OUT.
REQ-034 With CSA_SPLIT_CPA_EN defined, out_valid SHALL rise on the 3rd edge after the in_last acceptance edge.
REQ-035 Without CSA_SPLIT_CPA_EN, the single-edge full-width resolve of REQ-022 SHALL apply and RES_HI SHALL not exist.
REQ-036 Result values SHALL be identical in both configurations.

Verification (DW=8, GW=4, AW=12)
REQ-037 Beats 255, 255, 255, 1 (last) back-to-back -> out_data=0x2FE, out_valid on the 2nd edge after the last beat (3rd edge if CSA_SPLIT_CPA_EN).
REQ-038 Seventeen beats of 255 (last on the 17th) -> out_data=0x0EF (4335 mod 4096).
REQ-039 Single beat 0x5A with in_last=1 -> out_data=0x05A.
REQ-040 out_ready=0 for 5 cycles after out_valid rises -> out_data stable, in_ready=0, in_valid pulses ignored; out_ready=1 -> in_ready=1 in the next cycle.
REQ-041 Three beats of 10, then reset asserted for 1 cycle, then beat 7 with in_last=1 -> out_data=0x007.
REQ-042 Two consecutive groups {1,2,3 last} and {4 last} -> out_data=0x006 then 0x004, with no leakage between groups.

Source files
------------

// File: rtl/csa_accumulator.sv
// Carry-save group accumulator: sums unsigned beats in S/C form and resolves them with one carry-propagate add per group.
// Define CSA_SPLIT_CPA_EN to split the resolve add into a lower-half and an upper-half step.
module csa_accumulator #(
  parameter  int DW = 64,
  parameter  int GW = 4,
  localparam int AW = DW + GW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_data
);

`ifdef CSA_SPLIT_CPA_EN
  localparam int LW = (AW + 1) / 2;
  localparam int HW = AW - LW;

  typedef enum logic [1:0] {ACC, RES, RES_HI, OUT} state_t;
`else
  typedef enum logic [1:0] {ACC, RES, OUT} state_t;
`endif

  state_t        state_q, state_d;
  logic [AW-1:0] s_q, s_d;
  logic [AW-1:0] c_q, c_d;
  logic [AW-1:0] out_data_q, out_data_d;
  logic          in_ready_q, in_ready_d;
  logic          out_valid_q, out_valid_d;
  logic [AW-1:0] x;
  logic [AW-1:0] k;
`ifdef CSA_SPLIT_CPA_EN
  logic          carry_q, carry_d;
`endif

  assign x = {{GW{1'b0}}, in_data};
  // Carries carry weight two, so the C row is shifted up one place before use.
  assign k = {c_q[AW-2:0], 1'b0};

  always_comb begin
    state_d     = state_q;
    s_d         = s_q;
    c_d         = c_q;
    out_data_d  = out_data_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
`ifdef CSA_SPLIT_CPA_EN
    carry_d     = carry_q;
`endif

    case (state_q)
      ACC: begin
        if (in_valid && in_ready_q) begin
          s_d = x ^ s_q ^ k;
          c_d = (x & s_q) | (x & k) | (s_q & k);
          if (in_last) begin
            state_d    = RES;
            in_ready_d = 1'b0;
          end
        end
      end

`ifdef CSA_SPLIT_CPA_EN
      RES: begin
        {carry_d, out_data_d[LW-1:0]} = {1'b0, s_q[LW-1:0]} + {1'b0, k[LW-1:0]};
        state_d = RES_HI;
      end

      RES_HI: begin
        out_data_d[AW-1:LW] = s_q[AW-1:LW] + k[AW-1:LW] + {{(HW-1){1'b0}}, carry_q};
        s_d         = '0;
        c_d         = '0;
        state_d     = OUT;
        out_valid_d = 1'b1;
      end
`else
      RES: begin
        out_data_d  = s_q + k;
        s_d         = '0;
        c_d         = '0;
        state_d     = OUT;
        out_valid_d = 1'b1;
      end
`endif

      OUT: begin
        if (out_ready) begin
          state_d     = ACC;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end

      default: begin
        state_d     = ACC;
        s_d         = '0;
        c_d         = '0;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ACC;
      s_q         <= '0;
      c_q         <= '0;
      out_data_q  <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
`ifdef CSA_SPLIT_CPA_EN
      carry_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      c_q         <= c_d;
      out_data_q  <= out_data_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
`ifdef CSA_SPLIT_CPA_EN
      carry_q     <= carry_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule
